tinyalu_responder: RTL
======================

// Module: tinyalu_responder
// PURPOSE
//  Synthesizable responder for the TinyALU start/done command protocol; the DUT end of the stimulus BFM.
//  Captures A/B/op on a new start, computes add/and/xor/mul, and returns a 16-bit result with a one-cycle done pulse.
//  Sits below the interface as the device under test and is reused as the ALU core in the datapath.
// PARAMETERS
//  ALU_LAT  1  cycles from command capture to done for add/and/xor (legal range 1..4)
//  MUL_LAT  3  cycles from command capture to done for mul; equals the multiplier pipeline depth (legal range 1..8)
// PORTS
//  clk      in   1   clock, rising edge active
//  reset_n  in   1   reset, asynchronous, active-low
//  start    in   1   command valid; held high by the initiator until it samples done
//  A        in   8   operand A, unsigned
//  B        in   8   operand B, unsigned
//  op       in   3   opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101-111 illegal
//  done     out  1   one-cycle pulse; result is valid in the same cycle
//  result   out  16  result; holds its last value between done pulses
//  err      out  1   present only with TINYALU_ERR_EN; high together with done for an illegal opcode
// BEHAVIOUR
//  Reset: state=IDLE, done=0, result=16'h0000, err=0, start_q=0, pipeline cleared. Reset asynchronously aborts any command.
//  New command: posedge with start=1 and start_q=0 (start_q is start registered on the previous edge). Capture edge = T0.
//  FSM IDLE: on a new command, capture A, B and op.
//    - add/and/xor: go to BUSY, counter=ALU_LAT.
//    - mul: go to BUSY, counter=MUL_LAT, and launch the operands into tinyalu_mul_pipe.
//    - no_op: stay in IDLE; no done. start_q=1 blocks re-capture while start stays high.
//    - illegal opcode: treat as no_op (see CONFIGURATION for the TINYALU_ERR_EN case).
//  FSM BUSY: decrement the counter each edge. The registered done rises at edge T0+L (L = ALU_LAT or MUL_LAT).
//    - On that edge result is loaded; next state is DRAIN.
//    - If start is sampled low before T0+L: abort to IDLE; no done; result unchanged; the mul pipe result is discarded.
//  FSM DRAIN: done=0; wait until start is sampled low, then go to IDLE.
//    - A start that stays high after done never retriggers a command.
//  Arithmetic (operands zero-extended, result 16 bits):
//    - add = {7'b0, A+B}, 9-bit sum.
//    - and = {8'b0, A&B}.
//    - xor = {8'b0, A^B}.
//    - mul = A*B, unsigned 16-bit full product.
//  Operands and op are taken from the capture registers, not the live inputs. Input changes during BUSY are ignored.
//  Back-to-back commands: start must drop for at least one edge; the minimum command period is L+2 cycles.
//  done is never high for two consecutive cycles. The FSM is never in BUSY while done=1.
// CONFIGURATION
//  Macro TINYALU_ERR_EN:
//    - Defined: err port exists. An illegal opcode on a new command goes to BUSY with L=1.
//      done pulses with result=16'h0000 and err=1; err is 0 on every other cycle. Then DRAIN as normal.
//    - Undefined: no err port; illegal opcodes behave exactly as no_op.
// STRUCTURE
//  tinyalu_pkg:
//    - operation_t enum: no_op=3'b000, add_op=3'b001, and_op=3'b010, xor_op=3'b011, mul_op=3'b100, rst_op=3'b111.
//    - localparam ALU_W=8, RES_W=16.
//    - Function is_legal_op(op).
//    - rst_op has no hardware meaning; it is decoded as illegal.
//  Sub-module tinyalu_mul_pipe:
//    - Parameter STAGES=MUL_LAT; inputs valid_in, a, b, flush; outputs valid_out, prod.
//    - Synchronous pipeline; the flush input is driven on abort.
//  Top level: FSM (IDLE/BUSY/DRAIN), latency counter, start_q edge detector, capture regs, output regs.
// TESTING
//  T1 reset: hold reset_n=0 over 3 edges -> done=0, result=0, err=0. Assert reset mid-mul -> no done afterwards.
//  T2 add: A=8'hFF, B=8'h01, op=001, start held -> done one cycle at T0+1, result=16'h0100.
//     Then and/xor: A=8'hF0, B=8'h3C -> 16'h0030 / 16'h00CC.
//  T3 mul: A=8'hFF, B=8'hFF, op=100 -> done at T0+3, result=16'hFE01. No done at T0+1 or T0+2.
//  T4 no_op and DRAIN: op=000 pulsed for 1 cycle -> no done. add held high 5 cycles past done -> exactly one done pulse.
//  T5 abort: mul started, start dropped at T0+1 -> no done. result keeps its previous value; next add completes correctly.
//  T6 TINYALU_ERR_EN: op=110 -> done and err at T0+1, result=0. Without the macro -> no done, no port.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the TinyALU responder and its multiplier pipe.
// Optional build macro used by the responder: TINYALU_ERR_EN (adds the err port).
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    localparam int ALU_W = 8;
    localparam int RES_W = 16;

    // Wide enough for the largest legal latency (MUL_LAT up to 8).
    localparam int CNT_W = 4;

    // Opcodes 000..100 have a defined meaning; everything above is illegal.
    // rst_op is only a stimulus-side marker and carries no hardware meaning.
    function automatic logic is_legal_op(input logic [2:0] op_in);
        return (op_in <= 3'b100);
    endfunction

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Unsigned 8x8 multiplier pipeline for the TinyALU responder.
// The product is formed in the first stage and then delayed so the total
// latency from valid_in to valid_out is exactly STAGES clock edges.
// flush drops every in-flight valid bit so an aborted product never surfaces.
module tinyalu_mul_pipe
    import tinyalu_pkg::*;
#(
    parameter int STAGES = 3
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             flush,
    output logic             valid_out,
    output logic [RES_W-1:0] prod
);

    logic             valid_r [STAGES];
    logic [RES_W-1:0] prod_r  [STAGES];

    // Stage 0 multiplies, later stages only delay product and valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_r[i] <= 1'b0;
                prod_r[i]  <= '0;
            end
        end else begin
            valid_r[0] <= valid_in & ~flush;
            prod_r[0]  <= {{(RES_W-ALU_W){1'b0}}, a} * {{(RES_W-ALU_W){1'b0}}, b};
            for (int i = 1; i < STAGES; i++) begin
                valid_r[i] <= valid_r[i-1] & ~flush;
                prod_r[i]  <= prod_r[i-1];
            end
        end
    end

    assign valid_out = valid_r[STAGES-1];
    assign prod      = prod_r[STAGES-1];

endmodule

// File: rtl/tinyalu_responder.sv
// TinyALU responder: device end of the start/done command protocol.
// A rising start captures A/B/op, the result is returned after a fixed
// per-operation latency with a single-cycle done pulse, and the FSM then
// waits for start to drop before accepting the next command.
// Build macro TINYALU_ERR_EN: adds the err output; illegal opcodes then
// complete after one cycle with result 0 and err=1 instead of being ignored.
//
// state | meaning
// IDLE  | waiting for a new command (rising start)
// BUSY  | latency counter running; start dropping here aborts the command
// DRAIN | done has been issued; waiting for start to be released
module tinyalu_responder
    import tinyalu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 3
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic [2:0]       op,
    output logic             done,
`ifdef TINYALU_ERR_EN
    output logic             err,
`endif
    output logic [RES_W-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic             new_cmd;

    logic [ALU_W-1:0] a_q, a_d;
    logic [ALU_W-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;

    logic [RES_W-1:0] result_d;
    logic             done_d;
    logic             launch;
    logic             flush;

    logic             pipe_valid;
    logic [RES_W-1:0] pipe_prod;

`ifdef TINYALU_ERR_EN
    logic             err_q, err_d;
`endif

    // A command is only recognised on the first edge start is seen high.
    assign new_cmd = start & ~start_q;

    // Result selection for the captured operation; mul comes from the pipe.
    function automatic logic [RES_W-1:0] alu_calc(input logic [2:0]       op_in,
                                                  input logic [ALU_W-1:0] a_in,
                                                  input logic [ALU_W-1:0] b_in,
                                                  input logic             pv,
                                                  input logic [RES_W-1:0] pp);
        logic [RES_W-1:0] r;
        r = '0;
        case (operation_t'(op_in))
            add_op:  r = {7'b0, ({1'b0, a_in} + {1'b0, b_in})};
            and_op:  r = {8'b0, (a_in & b_in)};
            xor_op:  r = {8'b0, (a_in ^ b_in)};
            mul_op:  r = pv ? pp : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    tinyalu_mul_pipe #(
        .STAGES (MUL_LAT)
    ) u_mul_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (launch),
        .a         (A),
        .b         (B),
        .flush     (flush),
        .valid_out (pipe_valid),
        .prod      (pipe_prod)
    );

    // Next-state, counter, capture and output decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result;
        done_d   = 1'b0;
        launch   = 1'b0;
        flush    = 1'b0;
`ifdef TINYALU_ERR_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (new_cmd) begin
                    a_d  = A;
                    b_d  = B;
                    op_d = op;
                    case (operation_t'(op))
                        add_op, and_op, xor_op: begin
                            state_d = BUSY;
                            cnt_d   = CNT_W'(ALU_LAT);
                        end
                        mul_op: begin
                            state_d = BUSY;
                            cnt_d   = CNT_W'(MUL_LAT);
                            launch  = 1'b1;
                        end
                        default: begin
`ifdef TINYALU_ERR_EN
                            if (!is_legal_op(op)) begin
                                state_d = BUSY;
                                cnt_d   = CNT_W'(1);
                            end
`endif
                        end
                    endcase
                end
            end
            BUSY: begin
                // Completion wins on the terminal edge; earlier a low start aborts.
                if (cnt_q == CNT_W'(1)) begin
                    done_d   = 1'b1;
                    result_d = alu_calc(op_q, a_q, b_q, pipe_valid, pipe_prod);
                    state_d  = DRAIN;
`ifdef TINYALU_ERR_EN
                    err_d    = ~is_legal_op(op_q);
`endif
                end else if (!start) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DRAIN: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, capture and output registers; reset aborts everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            result  <= result_d;
            done    <= done_d;
        end
    end

`ifdef TINYALU_ERR_EN
    // err is a sibling of done and only ever rises with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule
